// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - shared state encoding and default constants for the playback repeat controller
package playback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int DEF_BIT_W    = 32;
    localparam int DEF_PKT_LAST = 936;
    localparam int DEF_REP_W    = 9;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo counter 0..LAST with enable, synchronous clear and terminal-count flag
module wrap_counter
    import playback_pkg::*;
#(
    parameter int LAST = DEF_BIT_W - 1,
    parameter int W    = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST_V = W'(LAST);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // wrap flags the terminal value; the parent qualifies it with its own enable
    assign wrap  = (count_q == LAST_V);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/playback_repeat_ctrl.sv
// rtl/playback_repeat_ctrl.sv - bit/packet/repetition sequencer for the serialiser; PLAYBACK_GAP_EN adds an inter-message gap
module playback_repeat_ctrl
    import playback_pkg::*;
#(
    parameter int BIT_W    = DEF_BIT_W,
    parameter int PKT_LAST = DEF_PKT_LAST,
    parameter int PKT_W    = 10,
    parameter int REP_W    = DEF_REP_W,
    parameter int BIT_CW   = $clog2(BIT_W)
`ifdef PLAYBACK_GAP_EN
    ,
    parameter int GAP_TICKS = 64
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_tick,
    input  logic [REP_W-1:0]  rep_target,
    output logic [BIT_CW-1:0] bit_count,
    output logic [PKT_W-1:0]  packet_count,
    output logic [REP_W-1:0]  big_count,
    output logic              playing,
    output logic              msg_wrap,
`ifdef PLAYBACK_GAP_EN
    output logic              in_gap,
`endif
    output logic              done
);

    state_e state_q;
    state_e state_d;

    logic [REP_W-1:0] big_q, big_d;
    logic [REP_W-1:0] target_q, target_d;
    logic             msg_wrap_q, msg_wrap_d;
    logic             done_q, done_d;
    logic             playing_q, playing_d;

    logic             run_tick;
    logic             play_tick;
    logic             bit_wrap;
    logic             pkt_wrap;
    logic             msg_end;
    logic             final_rep;
    logic [REP_W-1:0] big_inc;

`ifdef PLAYBACK_GAP_EN
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             in_gap_q, in_gap_d;
    logic             gap_done;
`endif

    // start and abort take precedence, so a tick only counts when neither is present
    assign run_tick  = bit_tick && !start && !abort;
    assign play_tick = (state_q == ST_PLAY) && run_tick;
    assign msg_end   = play_tick && bit_wrap && pkt_wrap;
    assign big_inc   = big_q + 1'b1;
    assign final_rep = msg_end && (target_q != '0) && (big_inc == target_q);

`ifdef PLAYBACK_GAP_EN
    assign gap_done  = (state_q == ST_GAP) && run_tick && (gap_q == GAP_LAST);
`endif

    wrap_counter #(
        .LAST (BIT_W - 1),
        .W    (BIT_CW)
    ) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (play_tick),
        .clr   (start),
        .count (bit_count),
        .wrap  (bit_wrap)
    );

    wrap_counter #(
        .LAST (PKT_LAST),
        .W    (PKT_W)
    ) u_pkt_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (play_tick && bit_wrap),
        .clr   (start),
        .count (packet_count),
        .wrap  (pkt_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_PLAY;
        end else if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (final_rep) begin
                        state_d = ST_IDLE;
                    end else if (msg_end) begin
`ifdef PLAYBACK_GAP_EN
                        state_d = ST_GAP;
`else
                        state_d = ST_PLAY;
`endif
                    end
                end
`ifdef PLAYBACK_GAP_EN
                ST_GAP: begin
                    if (gap_done) begin
                        state_d = ST_PLAY;
                    end
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        big_d    = big_q;
        target_d = target_q;
        if (start) begin
            big_d    = '0;
            target_d = rep_target;
        end else if (msg_end) begin
            big_d = big_inc;
        end
        msg_wrap_d = msg_end;
        done_d     = final_rep;
        playing_d  = (state_d != ST_IDLE);
`ifdef PLAYBACK_GAP_EN
        in_gap_d = (state_d == ST_GAP);
        gap_d    = gap_q;
        if (state_d != ST_GAP) begin
            gap_d = '0;
        end else if ((state_q == ST_GAP) && run_tick) begin
            gap_d = gap_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            big_q      <= '0;
            target_q   <= '0;
            msg_wrap_q <= 1'b0;
            done_q     <= 1'b0;
            playing_q  <= 1'b0;
`ifdef PLAYBACK_GAP_EN
            gap_q      <= '0;
            in_gap_q   <= 1'b0;
`endif
        end else begin
            big_q      <= big_d;
            target_q   <= target_d;
            msg_wrap_q <= msg_wrap_d;
            done_q     <= done_d;
            playing_q  <= playing_d;
`ifdef PLAYBACK_GAP_EN
            gap_q      <= gap_d;
            in_gap_q   <= in_gap_d;
`endif
        end
    end

    assign big_count = big_q;
    assign msg_wrap  = msg_wrap_q;
    assign done      = done_q;
    assign playing   = playing_q;
`ifdef PLAYBACK_GAP_EN
    assign in_gap    = in_gap_q;
`endif

endmodule

// File: tb/tb_playback_repeat_ctrl.sv
// tb/tb_playback_repeat_ctrl.sv - self-checking bench with a message-position reference model (PLAYBACK_GAP_EN aware)
module tb_playback_repeat_ctrl;

    localparam int BIT_W    = 4;
    localparam int PKT_LAST = 2;
    localparam int PKT_W    = 2;
    localparam int REP_W    = 3;
    localparam int BIT_CW   = 2;
    localparam int MSG      = BIT_W * (PKT_LAST + 1);
`ifdef PLAYBACK_GAP_EN
    localparam int GAP_TICKS = 5;
`else
    localparam int GAP_TICKS = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              bit_tick;
    logic [REP_W-1:0]  rep_target;
    logic [BIT_CW-1:0] bit_count;
    logic [PKT_W-1:0]  packet_count;
    logic [REP_W-1:0]  big_count;
    logic              playing;
    logic              msg_wrap;
    logic              done;
`ifdef PLAYBACK_GAP_EN
    logic              in_gap;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // reference model: position within the message plus repetitions completed
    int m_pos, m_big, m_tgt, m_gap;
    bit m_active, m_wrap, m_done;

    playback_repeat_ctrl #(
        .BIT_W    (BIT_W),
        .PKT_LAST (PKT_LAST),
        .PKT_W    (PKT_W),
        .REP_W    (REP_W),
        .BIT_CW   (BIT_CW)
`ifdef PLAYBACK_GAP_EN
        ,
        .GAP_TICKS(GAP_TICKS)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .bit_tick     (bit_tick),
        .rep_target   (rep_target),
        .bit_count    (bit_count),
        .packet_count (packet_count),
        .big_count    (big_count),
        .playing      (playing),
        .msg_wrap     (msg_wrap),
`ifdef PLAYBACK_GAP_EN
        .in_gap       (in_gap),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pos = 0; m_big = 0; m_tgt = 0; m_gap = 0;
        m_active = 1'b0; m_wrap = 1'b0; m_done = 1'b0;
    endfunction

    function automatic void model_step(input bit s, input bit a, input bit t, input int tg);
        m_wrap = 1'b0;
        m_done = 1'b0;
        if (s) begin
            m_pos = 0; m_big = 0; m_gap = 0;
            m_tgt = tg % (1 << REP_W);
            m_active = 1'b1;
        end else if (a) begin
            m_active = 1'b0;
            m_gap = 0;
        end else if (m_active && t) begin
            if (m_gap > 0) begin
                m_gap--;
            end else begin
                m_pos++;
                if (m_pos == MSG) begin
                    m_pos = 0;
                    m_big = (m_big + 1) % (1 << REP_W);
                    m_wrap = 1'b1;
                    if (m_tgt != 0 && m_big == m_tgt) begin
                        m_done = 1'b1;
                        m_active = 1'b0;
                    end else begin
                        m_gap = GAP_TICKS;
                    end
                end
            end
        end
    endfunction

    task automatic cyc(input bit s, input bit a, input bit t, input int tg);
        start = s; abort = a; bit_tick = t;
        rep_target = REP_W'(tg);
        @(posedge clk);
        model_step(s, a, t, tg);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("bit_count", int'(bit_count), m_pos % BIT_W);
            chk("packet_count", int'(packet_count), m_pos / BIT_W);
            chk("big_count", int'(big_count), m_big);
            chk("playing", int'(playing), int'(m_active));
            chk("msg_wrap", int'(msg_wrap), int'(m_wrap));
            chk("done", int'(done), int'(m_done));
`ifdef PLAYBACK_GAP_EN
            chk("in_gap", int'(in_gap), int'(m_active && m_gap > 0));
`endif
        end
    end

    initial begin
        int gap_hi;
        reset = 1'b1; start = 1'b0; abort = 1'b0; bit_tick = 1'b0; rep_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bit", int'(bit_count), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // ticks before any start are ignored
        repeat (3) cyc(0, 0, 1, 0);
        chk("idle_bit", int'(bit_count), 0);

        // finite target of 3
        cyc(1, 0, 0, 3);
        for (int i = 1; i <= 3 * MSG + 2 * GAP_TICKS; i++) begin
            cyc(0, 0, 1, 3);
`ifndef PLAYBACK_GAP_EN
            if (i == MSG) chk("wrap_at_12", int'(msg_wrap), 1);
            if (i == 2 * MSG) chk("big_at_24", int'(big_count), 2);
            if (i == 3 * MSG - 1) chk("no_done_35", int'(done), 0);
`endif
        end
        chk("done_final", int'(done), 1);
        chk("big_final", int'(big_count), 3);
        repeat (5) cyc(0, 0, 1, 3);
        chk("frozen_big", int'(big_count), 3);
        chk("frozen_playing", int'(playing), 0);

        // continuous play: big_count wraps modulo 8
        cyc(1, 0, 0, 0);
        for (int m = 1; m <= 9; m++) begin
            repeat (MSG) cyc(0, 0, 1, 0);
            if (m == 7) chk("cont_big7", int'(big_count), 7);
            if (m == 8) chk("cont_big0", int'(big_count), 0);
            if (m == 9) chk("cont_big1", int'(big_count), 1);
            repeat (GAP_TICKS) cyc(0, 0, 1, 0);
        end
        chk("cont_playing", int'(playing), 1);

        // restart coincident with the final tick
        cyc(1, 0, 0, 2);
        repeat (2 * MSG + GAP_TICKS - 1) cyc(0, 0, 1, 2);
        cyc(1, 0, 1, 2);
        chk("race_done", int'(done), 0);
        chk("race_bit", int'(bit_count), 0);
        chk("race_big", int'(big_count), 0);
        chk("race_playing", int'(playing), 1);

        // abort holds counters
        cyc(1, 0, 0, 3);
        repeat (6) cyc(0, 0, 1, 3);
        cyc(0, 1, 0, 3);
        chk("abort_bit", int'(bit_count), 2);
        chk("abort_pkt", int'(packet_count), 1);
        chk("abort_playing", int'(playing), 0);
        repeat (3) cyc(0, 0, 1, 3);
        chk("abort_hold", int'(bit_count), 2);
        cyc(1, 0, 0, 0);
        chk("restart_pkt", int'(packet_count), 0);

        // asynchronous reset mid-play
        repeat (7) cyc(0, 0, 1, 0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_bit", int'(bit_count), 0);
        chk("arst_pkt", int'(packet_count), 0);
        chk("arst_playing", int'(playing), 0);
        cyc(0, 0, 1, 0);
        reset = 1'b0;
        repeat (3) cyc(0, 0, 1, 0);
        chk("arst_idle", int'(bit_count), 0);

`ifdef PLAYBACK_GAP_EN
        // gap occupies exactly GAP_TICKS ticks between repetitions, none after the last
        cyc(1, 0, 0, 2);
        gap_hi = 0;
        for (int i = 1; i <= 2 * MSG + GAP_TICKS + 6; i++) begin
            cyc(0, 0, 1, 2);
            if (in_gap) gap_hi++;
            if (i == 2 * MSG + GAP_TICKS) chk("gap_done", int'(done), 1);
        end
        chk("gap_ticks", gap_hi, GAP_TICKS);
`endif

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) < 7, int'($urandom_range(0, 3)));
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
